// File: rtl/srlatch_writer_pkg.sv
// Shared definitions for the SR-latch writer: FSM states, default timing
// and the width of the phase counter.
package srl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } srl_state_e;

  localparam int CNT_W          = 4;
  localparam int DEF_PULSE_CYC  = 2;
  localparam int DEF_SETTLE_CYC = 3;
  localparam int SYNC_DEPTH     = 2;

  // A phase lasting cyc cycles is loaded with cyc-1 and left when the count hits 0.
  function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/srlatch_writer_cyc_counter.sv
// Loadable down-counter that stops at zero; times every FSM phase.
module cyc_counter
  import srl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/srlatch_writer.sv
// Drives active-low set/reset strobes into a bank of NAND SR latches, waits
// for them to settle, reads them back through a synchroniser and flags errors.
module srlatch_writer
  import srl_pkg::*;
#(
  parameter int N          = 8,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_mask,
  input  logic [N-1:0] req_data,
  output logic [N-1:0] ns,
  output logic [N-1:0] nr,
  input  logic [N-1:0] q_fb,
  output logic         done,
  output logic         err,
  output logic [N-1:0] err_bits
);

  localparam logic [CNT_W-1:0] PULSE_LD  = cyc_load(PULSE_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = cyc_load(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CHECK_LD  = cyc_load(SYNC_DEPTH);

  srl_state_e   state_q;
  logic [N-1:0] mask_q;
  logic [N-1:0] data_q;
  logic [N-1:0] ns_q;
  logic [N-1:0] nr_q;
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] err_bits_q;
  logic         done_q;
  logic         err_q;

  logic             ld_en;
  logic [CNT_W-1:0] ld_val;
  logic             cnt_zero;
  logic [N-1:0]     chk_bits;

  // Counter loads coincide with the state transition so each phase starts full.
  always_comb begin
    ld_en  = 1'b0;
    ld_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ld_en  = 1'b1;
          ld_val = (req_mask == '0) ? CHECK_LD : PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          ld_en  = 1'b1;
          ld_val = (SETTLE_CYC == 0) ? CHECK_LD : SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          ld_en  = 1'b1;
          ld_val = CHECK_LD;
        end
      end
      default: begin
        ld_en  = 1'b0;
        ld_val = '0;
      end
    endcase
  end

  cyc_counter u_cyc_counter (
    .clk        (clk),
    .rst        (reset),
    .load_i     (ld_en),
    .load_val_i (ld_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= q_fb;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid) begin
      mask_q <= req_mask;
      data_q <= req_data;
    end
  end

  assign chk_bits = mask_q & (sync2_q ^ data_q);

  // Strobes are built from a masked set/clear split, so ns and nr can never both be low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ns_q       <= '1;
      nr_q       <= '1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_mask == '0) begin
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_PULSE;
              ns_q    <= ~(req_mask & req_data);
              nr_q    <= ~(req_mask & ~req_data);
            end
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            ns_q    <= '1;
            nr_q    <= '1;
            state_q <= (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cnt_zero) begin
            done_q     <= 1'b1;
            err_bits_q <= chk_bits;
            err_q      <= |chk_bits;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign ns        = ns_q;
  assign nr        = nr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_bits  = err_bits_q;

endmodule

// File: tb/tb_srlatch_writer.sv
// Bench for srlatch_writer: NAND SR latch bank on ns/nr, table vectors,
// hand-written multi-cycle sequences and randomised writes against a model.
module tb_srlatch_writer;

  localparam int N = 8;
  localparam int P = 2;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_mask;
  logic [N-1:0] req_data;
  logic [N-1:0] ns;
  logic [N-1:0] nr;
  logic [N-1:0] q_fb;
  logic         done;
  logic         err;
  logic [N-1:0] err_bits;

  logic [N-1:0] q_latch;
  logic [N-1:0] force_en;
  logic [N-1:0] force_val;
  logic [N-1:0] mdl_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srlatch_writer #(.N(N), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .req_data  (req_data),
    .ns        (ns),
    .nr        (nr),
    .q_fb      (q_fb),
    .done      (done),
    .err       (err),
    .err_bits  (err_bits)
  );

  // NAND SR latch per bit: low ns sets, low nr clears, both high holds.
  for (genvar i = 0; i < N; i++) begin : g_nand_srlatch
    logic q_r = 1'b0;
    always @(ns[i] or nr[i]) begin
      if (!ns[i]) q_r = 1'b1;
      else if (!nr[i]) q_r = 1'b0;
    end
    assign q_latch[i] = q_r;
  end

  assign q_fb = (q_latch & ~force_en) | (force_val & force_en);

  always @(negedge clk) begin
    checks++;
    if ((~ns & ~nr) != '0) begin
      errors++;
      $display("FAIL strobe_overlap: ns=%h nr=%h, required no bit with both low", ns, nr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Spec-level model: masked bits take data, the rest hold; mismatches seen on the readback.
  task automatic model_write(input logic [N-1:0] m, input logic [N-1:0] d,
                             output logic [N-1:0] exp_bits);
    logic [N-1:0] fin, obs;
    fin      = (mdl_q & ~m) | (d & m);
    obs      = (fin & ~force_en) | (force_val & force_en);
    exp_bits = m & (obs ^ d);
    mdl_q    = fin;
  endtask

  // Called at a negedge with the writer idle; returns at the negedge showing done.
  task automatic txn(input logic [N-1:0] m, input logic [N-1:0] d,
                     input logic [N-1:0] exp_bits, input bit keep,
                     input logic [N-1:0] nm, input logic [N-1:0] nd, input string tag);
    int lat;
    logic [N-1:0] ens, enr;
    lat = (m == '0) ? 3 : 1 + P + S + 2;
    check({tag, " ready_before"}, req_ready, 1);
    req_valid = 1'b1;
    req_mask  = m;
    req_data  = d;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (m != '0 && k <= P) begin
        ens = ~(m & d);
        enr = ~(m & ~d);
      end else begin
        ens = '1;
        enr = '1;
      end
      check($sformatf("%s ns k=%0d", tag, k), ns, ens);
      check($sformatf("%s nr k=%0d", tag, k), nr, enr);
      if (k < lat) begin
        check($sformatf("%s done k=%0d", tag, k), done, 0);
        check($sformatf("%s ready k=%0d", tag, k), req_ready, 0);
      end else begin
        check({tag, " done"}, done, 1);
        check({tag, " ready_after"}, req_ready, 1);
        check({tag, " err"}, err, |exp_bits);
        check({tag, " err_bits"}, err_bits, exp_bits);
      end
      if (k == 1) begin
        if (keep) begin
          req_mask = nm;
          req_data = nd;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] data;
    logic [N-1:0] fen;
    logic [N-1:0] fval;
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_bits;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] eb;
    logic [N-1:0] m, d;
    bit seen_done;

    vecs[0] = '{8'hFF, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00};
    vecs[3] = '{8'h00, 8'h5A, 8'h00, 8'h00, 8'hF0, 8'h00};
    vecs[4] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'hF4, 8'h04};
    vecs[5] = '{8'hF0, 8'h0F, 8'h01, 8'h01, 8'h04, 8'h00};
    vecs[6] = '{8'hFF, 8'h3C, 8'h81, 8'h81, 8'h3C, 8'h81};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_mask  = '0;
    req_data  = '0;
    force_en  = '0;
    force_val = '0;
    mdl_q     = '0;

    repeat (2) @(negedge clk);
    check("reset ns", ns, 8'hFF);
    check("reset nr", nr, 8'hFF);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset err_bits", err_bits, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset ready", req_ready, 1);

    for (int i = 0; i < 7; i++) begin
      force_en  = vecs[i].fen;
      force_val = vecs[i].fval;
      txn(vecs[i].mask, vecs[i].data, vecs[i].exp_bits, 1'b0, '0, '0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d latch_q", i), q_latch, vecs[i].exp_q);
      @(negedge clk);
    end
    force_en  = '0;
    force_val = '0;
    mdl_q     = vecs[6].exp_q;

    // Back-to-back: valid stays high, second request presented while busy.
    model_write(8'hFF, 8'hC3, eb);
    txn(8'hFF, 8'hC3, eb, 1'b1, 8'h0F, 8'h0A, "b2b_first");
    check("b2b_first latch_q", q_latch, 8'hC3);
    model_write(8'h0F, 8'h0A, eb);
    txn(8'h0F, 8'h0A, eb, 1'b0, '0, '0, "b2b_second");
    check("b2b_second latch_q", q_latch, 8'hCA);
    @(negedge clk);

    // Reset during the second pulse cycle aborts the write without a done.
    req_valid = 1'b1;
    req_mask  = 8'hFF;
    req_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort nr_pulse", nr, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort ns", ns, 8'hFF);
    check("abort nr", nr, 8'hFF);
    check("abort ready", req_ready, 1);
    check("abort done", done, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort no_done", seen_done, 0);
    mdl_q = 8'h00;
    check("abort latch_q", q_latch, mdl_q);

    for (int it = 0; it < 24; it++) begin
      m = (it % 5 == 0) ? 8'h00 : N'($urandom);
      d = N'($urandom);
      force_en  = (it % 4 == 3) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      force_val = N'($urandom);
      model_write(m, d, eb);
      txn(m, d, eb, 1'b0, '0, '0, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d latch_q", it), q_latch, mdl_q);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srlatch_writer.md
SRLATCH_WRITER -- requirements
Module: srlatch_writer

Interface
REQ-001 Parameter N, default 8, number of latch bits driven.
REQ-002 Parameter PULSE_CYC, default 2, cycles an active-low strobe is held; legal 1..15.
REQ-003 Parameter SETTLE_CYC, default 3, cycles waited after strobe release before readback; legal 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  write request present.
REQ-007 req_ready  output  1  writer can accept a request.
REQ-008 req_mask  input  N  bits to be written; 0 = leave latch untouched.
REQ-009 req_data  input  N  target latch value per masked bit.
REQ-010 ns  output  N  active-low set strobe to each latch.
REQ-011 nr  output  N  active-low reset strobe to each latch.
REQ-012 q_fb  input  N  latch q readback; treated as asynchronous, double-flop synchronised.
REQ-013 done  output  1  one-cycle pulse on write completion.
REQ-014 err  output  1  valid with done; 1 = a masked bit read back wrong.
REQ-015 err_bits  output  N  valid with done; masked bits where synchronised q_fb != req_data.

Function
REQ-016 FSM states: IDLE, PULSE, SETTLE, CHECK.
REQ-017 IDLE: req_ready=1; on req_valid&&req_ready, mask and data are captured into registers -> PULSE next cycle.
REQ-018 Request with req_mask==0: captured, skips PULSE/SETTLE -> CHECK; done pulses with err=0, err_bits=0.
REQ-019 PULSE: for masked bits, ns[i]=!data[i], nr[i]=data[i]; unmasked bits ns=nr=1; held exactly PULSE_CYC cycles.
REQ-020 ns[i] and nr[i] SHALL never both be 0 in any cycle, including reset and state transitions.
REQ-021 SETTLE: all ns=nr=1 for SETTLE_CYC cycles (0 = go straight to CHECK); then CHECK.
REQ-022 CHECK occupies 2 cycles (synchroniser depth) then compares; done=1 for one cycle; returns to IDLE.
REQ-023 Latency from accept to done = 1 + PULSE_CYC + SETTLE_CYC + 2 cycles (mask==0: 3 cycles).
REQ-024 req_ready=0 in every state except IDLE; req_valid outside IDLE ignored, no queueing.
REQ-025 Back-to-back: a request valid in the cycle after done is accepted that cycle.
REQ-026 Cycle counter 4 bits, loaded on state entry, decrements to 0; no wrap.
REQ-027 err = |err_bits; err_bits masked by captured mask; unmasked q_fb values never cause err.
REQ-028 done, err, err_bits are registered outputs.

Reset
REQ-029 reset SHALL return FSM to IDLE from any state in the next cycle, aborting any strobe.
REQ-030 During and after reset: ns=all 1, nr=all 1, req_ready=1 after release, done=0, err=0, err_bits=0, counter=0, synchroniser flops=0.
REQ-031 reset mid-PULSE SHALL produce no done pulse for the aborted request.

Structure
REQ-032 Shared package srl_pkg holds: FSM state enum, default PULSE_CYC/SETTLE_CYC constants, counter width constant.
REQ-033 One sub-module: cyc_counter (loadable 4-bit down-counter with zero flag), instantiated once.
REQ-034 Synchroniser is inline two flop stages on q_fb, not a separate module.
REQ-035 Bench SHALL connect N nand_srlatch instances to ns/nr/q_fb as the latch model.

Verification
REQ-036 Reset, then mask=8'hFF data=8'hA5 -> ns=8'h5A nr=8'hA5 for 2 cycles, done at cycle 8 after accept, err=0, latches read 8'hA5.
REQ-037 Latches at 8'hFF, mask=8'h0F data=8'h00 -> only bits 3:0 strobed via nr; final q=8'hF0, err=0.
REQ-038 mask=8'h00 -> no strobe asserted, done 3 cycles after accept, err=0.
REQ-039 Bit 2 q_fb forced to 0, mask=8'h04 data=8'h04 -> done with err=1, err_bits=8'h04.
REQ-040 reset asserted in 2nd PULSE cycle -> next cycle ns=nr=8'hFF, state IDLE, no done; checker confirms !(~ns & ~nr) every cycle.
REQ-041 req_valid held high across two requests -> second accepted in cycle after first done; req_valid during busy ignored.
